vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, meaning the pixel ticks per line.
REQ-002 SHALL have parameter H_ACT_START, default 144, meaning the ticks from the HSYNC falling edge to the first active pixel.
REQ-003 SHALL have parameter H_ACTIVE, default 640, meaning the active pixels per line.
REQ-004 SHALL have parameter V_TOTAL, default 525, meaning the lines per frame.
REQ-005 SHALL have parameter V_ACT_START, default 35, meaning the lines from the VSYNC falling edge to the first active line.
REQ-006 SHALL have parameter V_ACTIVE, default 480, meaning the active lines per frame.
REQ-007 SHALL have parameter LOCK_FRAMES, default 2, meaning the consecutive good frames required to lock.
REQ-008 SHALL have port CLKIN, input, 1 bit: the single clock; all logic on its rising edge.
REQ-009 SHALL have port RESET, input, 1 bit: the reset, synchronous and active-low.
REQ-010 SHALL have port PIXELTICK, input, 1 bit: one-CLKIN-wide pixel enable.
REQ-011 SHALL have port HSYNC, input, 1 bit: horizontal sync, active-low.
REQ-012 SHALL have port VSYNC, input, 1 bit: vertical sync, active-low.
REQ-013 SHALL have port RGBIN, input, 12 bits: incoming pixel colour.
REQ-014 SHALL have port pixel_x, output, 10 bits: recovered column, 0..639.
REQ-015 SHALL have port pixel_y, output, 10 bits: recovered row, 0..479.
REQ-016 SHALL have port video_on, output, 1 bit: the captured pixel is active and the decoder is locked.
REQ-017 SHALL have port RGBCAP, output, 12 bits: the captured pixel colour.
REQ-018 SHALL have port pix_valid, output, 1 bit: one-cycle strobe marking a new captured pixel.
REQ-019 SHALL have port frame_start, output, 1 bit: one-cycle pulse on a VSYNC falling edge.
REQ-020 SHALL have port locked, output, 1 bit: timing lock status.
REQ-021 SHALL have port sync_err, output, 1 bit: one-cycle pulse on any timing violation.

Function
REQ-022 All state except the pulse outputs SHALL update only on CLKIN edges where PIXELTICK=1 (the "tick").
REQ-023 Pulse outputs (pix_valid, frame_start, sync_err) SHALL be 1 only in the single cycle following the tick that caused them, and 0 otherwise.
REQ-024 SHALL register HSYNC and VSYNC on each tick into hs_d and vs_d; on that tick hs_fall = hs_d & ~HSYNC and vs_fall = vs_d & ~VSYNC.
REQ-025 hcnt (10 bits), on a tick: 0 if hs_fall; else +1 if below 1023; else hold at 1023.
REQ-026 Line check: on hs_fall, prior hcnt != H_TOTAL-1 SHALL flag line_err; hcnt reaching 1023 SHALL flag line_err once.
REQ-027 vcnt (10 bits), on a tick: 0 if vs_fall, taking priority over everything else; else +1 when hcnt goes from H_ACT_START-1 to H_ACT_START; saturate at 1023.
REQ-028 Frame check: on vs_fall, prior vcnt not in {V_TOTAL-1, V_TOTAL} SHALL flag frame_err.
REQ-029 sync_err SHALL pulse on line_err or frame_err only in ACQUIRE or LOCKED.
REQ-030 The FSM SHALL have states SEARCH, ACQUIRE and LOCKED; reset state is SEARCH.
REQ-031 SEARCH SHALL go to ACQUIRE on vs_fall and clear good_cnt to 0.
REQ-032 ACQUIRE: on error, go to SEARCH; on vs_fall with no error, increment good_cnt, and go to LOCKED once good_cnt reaches LOCK_FRAMES.
REQ-033 LOCKED: on error, go to SEARCH; otherwise hold.
REQ-034 In all states, an error and a vs_fall on the same tick SHALL resolve as an error.
REQ-035 locked SHALL be 1 exactly while the state is LOCKED, changing the cycle after the deciding tick.
REQ-036 active SHALL equal (H_ACT_START <= hcnt < H_ACT_START+H_ACTIVE) and (V_ACT_START <= vcnt < V_ACT_START+V_ACTIVE), evaluated on the post-update counters.
REQ-037 On a tick with active=1 and LOCKED: RGBCAP<=RGBIN, pixel_x<=hcnt-H_ACT_START, pixel_y<=vcnt-V_ACT_START, video_on<=1, pix_valid<=1; otherwise video_on<=0 and the other outputs hold.
REQ-038 Capture latency SHALL be exactly one CLKIN cycle after the sampling tick.
REQ-039 frame_start SHALL pulse on every vs_fall in any state.
REQ-040 Arithmetic SHALL be unsigned 10-bit; subtractions are only evaluated inside active ranges and cannot underflow.

Reset
REQ-041 With RESET=0 on a CLKIN edge, regardless of PIXELTICK, SHALL clear all state and outputs: hs_d=1, vs_d=1, hcnt=0, vcnt=0, good_cnt=0, state=SEARCH.
REQ-042 Reset SHALL clear pixel_x, pixel_y, RGBCAP, video_on, pix_valid, frame_start, locked and sync_err to 0.
REQ-043 Reset mid-frame SHALL require a fresh VSYNC fall plus LOCK_FRAMES good frames before locked=1.

Verification
REQ-044 Drive standard 640x480 timing (PIXELTICK every 4 clocks) for 3 frames -> locked rises the cycle after the 3rd VSYNC fall, counting the 1st as entry to ACQUIRE; sync_err stays 0.
REQ-045 Locked, RGBIN = {pixel_x[3:0], pixel_y[3:0], 4'hA} pattern -> captured (x,y) = (0,0) first, (639,479) last, 307200 pix_valid per frame, with matching RGBCAP.
REQ-046 Locked, one line of 801 ticks -> a sync_err pulse, locked falls next cycle, and no pix_valid until relock.
REQ-047 Locked, one frame of 524 lines -> frame_err and sync_err, state returns to SEARCH, and relock happens after 2 further good frames.
REQ-048 HSYNC held high for 1100 ticks -> hcnt saturates at 1023 and line_err pulses exactly once.
REQ-049 RESET=0 for one cycle at pixel (320,240) of a locked frame -> all outputs 0 next cycle, and locked stays 0 until REQ-043 is satisfied.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates from incoming VGA sync timing,
// checks line/frame lengths, locks after a run of good frames and captures the
// active pixels while locked.
//
// Ports:
//   CLKIN       single clock, rising edge
//   RESET       synchronous, active-low
//   PIXELTICK   one-CLKIN-wide pixel enable; all timing state advances on it
//   HSYNC/VSYNC active-low syncs
//   RGBIN       12-bit incoming pixel colour
//   pixel_x/y   coordinates of the last captured pixel
//   video_on    last tick captured an active pixel while locked
//   RGBCAP      last captured colour
//   pix_valid   one-cycle strobe per captured pixel
//   frame_start one-cycle pulse per VSYNC falling edge
//   locked      timing lock status
//   sync_err    one-cycle pulse per timing violation while acquiring/locked
module vga_sync_decoder #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_ACT_START = 144,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_ACT_START = 35,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        CLKIN,
    input  logic        RESET,
    input  logic        PIXELTICK,
    input  logic        HSYNC,
    input  logic        VSYNC,
    input  logic [11:0] RGBIN,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_on,
    output logic [11:0] RGBCAP,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err
);

    localparam int unsigned CW   = 10;
    localparam int unsigned CMAX = 1023;
    localparam int unsigned GW   = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            hs_d;
    logic            vs_d;
    logic [CW-1:0]   hcnt;
    logic [CW-1:0]   vcnt;
    logic [GW-1:0]   good_cnt;

    logic            hs_fall;
    logic            vs_fall;
    logic [CW-1:0]   hcnt_n;
    logic [CW-1:0]   vcnt_n;
    logic [GW-1:0]   good_n;
    logic [GW-1:0]   good_inc;
    logic            line_err;
    logic            frame_err;
    logic            err;
    logic            active;

    // Next-tick counters, error detection and lock decision
    always_comb begin
        hs_fall   = hs_d & ~HSYNC;
        vs_fall   = vs_d & ~VSYNC;

        hcnt_n = hcnt;
        if (hs_fall)
            hcnt_n = '0;
        else if (hcnt != CW'(CMAX))
            hcnt_n = hcnt + CW'(1);

        // A short/long line is caught at its HSYNC fall; a missing HSYNC is
        // caught once, on the step into saturation.
        line_err = (hs_fall && (hcnt != CW'(H_TOTAL - 1))) ||
                   (!hs_fall && (hcnt == CW'(CMAX - 1)));

        // Lines are counted where hcnt steps into the active-start column.
        vcnt_n = vcnt;
        if (vs_fall)
            vcnt_n = '0;
        else if (!hs_fall && (hcnt == CW'(H_ACT_START - 1)) && (vcnt != CW'(CMAX)))
            vcnt_n = vcnt + CW'(1);

        frame_err = vs_fall && (vcnt != CW'(V_TOTAL - 1)) && (vcnt != CW'(V_TOTAL));
        err       = line_err | frame_err;

        active = (hcnt_n >= CW'(H_ACT_START)) &&
                 (hcnt_n <  CW'(H_ACT_START + H_ACTIVE)) &&
                 (vcnt_n >= CW'(V_ACT_START)) &&
                 (vcnt_n <  CW'(V_ACT_START + V_ACTIVE));

        good_inc = good_cnt + GW'(1);
        state_n  = state;
        good_n   = good_cnt;
        case (state)
            SEARCH: begin
                if (!err && vs_fall) begin
                    state_n = ACQUIRE;
                    good_n  = '0;
                end
            end
            ACQUIRE: begin
                if (err) begin
                    state_n = SEARCH;
                end else if (vs_fall) begin
                    good_n = good_inc;
                    if (good_inc >= GW'(LOCK_FRAMES))
                        state_n = LOCKED;
                end
            end
            LOCKED: begin
                if (err)
                    state_n = SEARCH;
            end
            default: state_n = SEARCH;
        endcase
    end

    // Timing state, FSM and registered outputs
    always_ff @(posedge CLKIN) begin
        if (!RESET) begin
            state       <= SEARCH;
            hs_d        <= 1'b1;
            vs_d        <= 1'b1;
            hcnt        <= '0;
            vcnt        <= '0;
            good_cnt    <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            RGBCAP      <= '0;
            video_on    <= 1'b0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            if (PIXELTICK) begin
                hs_d        <= HSYNC;
                vs_d        <= VSYNC;
                hcnt        <= hcnt_n;
                vcnt        <= vcnt_n;
                good_cnt    <= good_n;
                state       <= state_n;
                locked      <= (state_n == LOCKED);
                frame_start <= vs_fall;
                sync_err    <= err && (state != SEARCH);
                // Capture gated by the lock state the tick started in
                if (active && (state == LOCKED)) begin
                    RGBCAP    <= RGBIN;
                    pixel_x   <= hcnt_n - CW'(H_ACT_START);
                    pixel_y   <= vcnt_n - CW'(V_ACT_START);
                    video_on  <= 1'b1;
                    pix_valid <= 1'b1;
                end else begin
                    video_on  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down raster (20 ticks x 12 lines,
// 10x6 active) so whole frames stay short. Stimulus pushes the expected
// captured pixels into a scoreboard queue; a forked monitor pops on pix_valid.
module tb_vga_sync_decoder;

    localparam int unsigned HT  = 20;
    localparam int unsigned HAS = 6;
    localparam int unsigned HA  = 10;
    localparam int unsigned VT  = 12;
    localparam int unsigned VAS = 3;
    localparam int unsigned VA  = 6;
    localparam int unsigned LF  = 2;
    localparam int          BIG = 1000000;
    localparam int          PIX_PER_FRAME = HA * VA;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pixeltick;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgbin;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic [11:0] rgbcap;
    logic        pix_valid;
    logic        frame_start;
    logic        locked;
    logic        sync_err;

    pix_t sb[$];
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   n_sync = 0;
    int   n_fs   = 0;
    int   n_pop  = 0;
    logic pre_lk;
    logic post_lk;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_ACT_START(VAS), .V_ACTIVE(VA),
        .LOCK_FRAMES(LF)
    ) dut (
        .CLKIN(clk), .RESET(rst_n), .PIXELTICK(pixeltick),
        .HSYNC(hsync), .VSYNC(vsync), .RGBIN(rgbin),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .RGBCAP(rgbcap), .pix_valid(pix_valid), .frame_start(frame_start),
        .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        pix_t e;
        forever begin
            @(negedge clk);
            if (sync_err)    n_sync++;
            if (frame_start) n_fs++;
            if (pix_valid) begin
                n_pop++;
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_capture: got x=%0d y=%0d rgb=%h, required no pix_valid",
                             pixel_x, pixel_y, rgbcap);
                end else begin
                    e = sb.pop_front();
                    if ({video_on, pixel_x, pixel_y, rgbcap} !== {1'b1, e.x, e.y, e.rgb}) begin
                        n_bad++;
                        $display("FAIL capture: got on=%0b x=%0d y=%0d rgb=%h, required on=1 x=%0d y=%0d rgb=%h",
                                 video_on, pixel_x, pixel_y, rgbcap, e.x, e.y, e.rgb);
                    end
                end
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_locked"},      32'(locked),      32'd0);
        check({tag, "_video_on"},    32'(video_on),    32'd0);
        check({tag, "_pix_valid"},   32'(pix_valid),   32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        check({tag, "_sync_err"},    32'(sync_err),    32'd0);
        check({tag, "_pixel_x"},     32'(pixel_x),     32'd0);
        check({tag, "_pixel_y"},     32'(pixel_y),     32'd0);
        check({tag, "_rgbcap"},      32'(rgbcap),      32'd0);
    endtask

    // Reset held over several edges with a live tick and falling syncs
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; pixeltick = 1'b1; hsync = 1'b0; vsync = 1'b0; rgbin = 12'hFFF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; pixeltick = 1'b0; hsync = 1'b1; vsync = 1'b1; rgbin = 12'h000;
    endtask

    // One pixel tick every 4 clocks; records lock before and after the tick
    task automatic tick(input logic hs, input logic vs, input logic [11:0] rgb);
        @(negedge clk);
        pre_lk = locked;
        hsync = hs; vsync = vs; rgbin = rgb; pixeltick = 1'b1;
        @(negedge clk);
        pixeltick = 1'b0;
        post_lk = locked;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Drives one frame. Pixels at tick index k < cap_to are expected captured.
    // edge_k returns the first tick index whose tick changed locked (-1: none).
    task automatic drive_frame(input int nlines, input bit vs_on, input int long_line,
                               input int cap_to, input int rst_at, output int edge_k);
        int k = 0;
        edge_k = -1;
        for (int l = 0; l < nlines; l++) begin
            int len = (l == long_line) ? int'(HT) + 1 : int'(HT);
            for (int t = 0; t < len; t++) begin
                logic [9:0]  xb = 10'(t - int'(HAS));
                logic [9:0]  yb = 10'(l + 1 - int'(VAS));
                logic [11:0] rgb;
                bit act = (t >= int'(HAS)) && (t < int'(HAS + HA)) &&
                          (l + 1 >= int'(VAS)) && (l + 1 < int'(VAS + VA));
                rgb = act ? {xb[3:0], yb[3:0], 4'hA} : 12'h5C3;
                if (act && k < cap_to)
                    sb.push_back('{x: xb, y: yb, rgb: rgb});
                tick(!(t < 2), !(vs_on && l < 2), rgb);
                if (edge_k < 0 && pre_lk !== post_lk)
                    edge_k = k;
                if (k == rst_at) begin
                    @(negedge clk);
                    rst_n = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    check_zero("midframe_reset");
                end
                k++;
            end
        end
    endtask

    initial begin
        int e;
        int fall;
        rst_n = 1'b1; pixeltick = 1'b0; hsync = 1'b1; vsync = 1'b1; rgbin = 12'h000;
        fork
            monitor();
        join_none

        // Reset state
        do_reset();
        check_zero("reset");

        // Acquire and lock on clean timing; preamble lines give a valid first frame
        drive_frame(VT, 1'b0, -1, 0, -1, e);
        check("preamble_edge", 32'(e), 32'(-1));
        drive_frame(VT, 1'b1, -1, 0, -1, e);
        check("f1_acquire_no_lock", 32'(e), 32'(-1));
        drive_frame(VT, 1'b1, -1, 0, -1, e);
        check("f2_no_lock", 32'(e), 32'(-1));
        n_pop = 0;
        drive_frame(VT, 1'b1, -1, BIG, -1, e);
        check("f3_lock_at_vsync", 32'(e), 32'd0);
        check("f3_locked", 32'(locked), 32'd1);
        drive_frame(VT, 1'b1, -1, BIG, -1, e);
        check("f4_stay_locked", 32'(e), 32'(-1));
        check("pixels_two_frames", 32'(n_pop), 32'(2 * PIX_PER_FRAME));
        check("no_sync_err_clean", 32'(n_sync), 32'd0);
        check("frame_start_count", 32'(n_fs), 32'd4);

        // One overlong line (line 4): error seen at the next HSYNC fall, tick 101
        n_sync = 0; n_pop = 0;
        drive_frame(VT, 1'b1, 4, 101, -1, e);
        check("long_line_unlock_tick", 32'(e), 32'd101);
        check("long_line_sync_err", 32'(n_sync), 32'd1);
        check("long_line_pixels", 32'(n_pop), 32'(3 * HA));
        drive_frame(VT, 1'b1, -1, 0, -1, e);
        check("relock1_none", 32'(e), 32'(-1));
        drive_frame(VT, 1'b1, -1, 0, -1, e);
        check("relock2_none", 32'(e), 32'(-1));
        drive_frame(VT, 1'b1, -1, BIG, -1, e);
        check("relock_after_long_line", 32'(e), 32'd0);

        // A frame two lines short: frame error on the following VSYNC fall
        n_sync = 0; n_fs = 0;
        drive_frame(VT - 2, 1'b1, -1, BIG, -1, e);
        check("short_frame_still_locked", 32'(e), 32'(-1));
        drive_frame(VT, 1'b1, -1, 0, -1, e);
        check("short_frame_unlock", 32'(e), 32'd0);
        check("short_frame_sync_err", 32'(n_sync), 32'd1);
        drive_frame(VT, 1'b1, -1, 0, -1, e);
        check("short_relock1_none", 32'(e), 32'(-1));
        drive_frame(VT, 1'b1, -1, 0, -1, e);
        check("short_relock2_none", 32'(e), 32'(-1));
        drive_frame(VT, 1'b1, -1, BIG, -1, e);
        check("short_relock", 32'(e), 32'd0);
        check("short_frame_start_count", 32'(n_fs), 32'd5);
        check("short_sync_err_total", 32'(n_sync), 32'd1);

        // HSYNC stuck high: hcnt 19 -> saturation reached on hold tick 1003
        n_sync = 0; fall = -1;
        for (int i = 0; i < 1100; i++) begin
            tick(1'b1, 1'b1, 12'h5C3);
            if (fall < 0 && pre_lk !== post_lk)
                fall = i;
        end
        check("hold_sync_err_once", 32'(n_sync), 32'd1);
        check("hold_unlock_tick", 32'(fall), 32'd1003);

        // Reset mid-frame right after pixel (5,3) (line 5, tick 11, k=111)
        do_reset();
        check_zero("reset2");
        drive_frame(VT, 1'b0, -1, 0, -1, e);
        drive_frame(VT, 1'b1, -1, 0, -1, e);
        drive_frame(VT, 1'b1, -1, 0, -1, e);
        drive_frame(VT, 1'b1, -1, BIG, -1, e);
        check("t4_lock", 32'(e), 32'd0);
        drive_frame(VT, 1'b1, -1, 112, 111, e);
        check("t4_reset_frame_edge", 32'(e), 32'(-1));
        drive_frame(VT, 1'b1, -1, 0, -1, e);
        check("t4_partial_vsync_no_lock", 32'(e), 32'(-1));
        drive_frame(VT, 1'b1, -1, 0, -1, e);
        check("t4_acquire_no_lock", 32'(e), 32'(-1));
        drive_frame(VT, 1'b1, -1, 0, -1, e);
        check("t4_good1_no_lock", 32'(e), 32'(-1));
        check("t4_still_unlocked", 32'(locked), 32'd0);
        drive_frame(VT, 1'b1, -1, BIG, -1, e);
        check("t4_relock", 32'(e), 32'd0);

        repeat (8) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
